// File: rtl/brisc_pkg.sv
// brisc_pkg: shared constants and types for the brisc fetch front-end.
//   XLEN / ILEN   : PC and instruction widths
//   PC_BOOT       : reset fetch address
//   IFQ_DEPTH     : default instruction-queue depth
//   fetch_entry_t : one queued fetch, {pc, instr}
//   sat_inc32     : saturating 32-bit increment used by the perf counters
package brisc_pkg;

  localparam int XLEN      = 32;
  localparam int ILEN      = 32;
  localparam int IFQ_DEPTH = 4;

  localparam logic [XLEN-1:0] PC_BOOT = 32'h0000_1000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous circular FIFO holding fetch entries.
//   clk, reset : clock, synchronous active-high reset (control only)
//   flush      : empties the queue; overrides push/pop
//   push/wdata : write wdata at tail
//   pop        : retire head (caller guarantees !empty)
//   rdata      : head entry (contents undefined while empty)
//   full/empty/count : occupancy status
// Simultaneous push and pop is legal when full (count unchanged).
module ifetch_fifo
  import brisc_pkg::*;
#(
  parameter int  DEPTH   = IFQ_DEPTH,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  entry_t                    wdata,
  output entry_t                    rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  entry_t             r_mem [DEPTH];
  logic [IDX_W-1:0]   r_head;
  logic [IDX_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_tail <= r_tail + IDX_W'(1);
      if (pop)  r_head <= r_head + IDX_W'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the occupancy count alone says what is live.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_tail] <= wdata;
  end

  assign rdata = r_mem[r_head];
  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/ifetch_queue_stage.sv
// ifetch_queue_stage: PC generation plus an instruction queue between the
// icache and decode. Fetches sequentially from BOOT_PC on icache hits while
// the queue has room; a redirect flushes the queue and restarts at the target.
//   clk, reset                 : clock, synchronous active-high reset
//   stall_fetch                : hazard hold (freezes PC, blocks push)
//   redirect, redirect_target  : flush + restart (target bits [1:0] ignored)
//   icache_req, icache_addr    : fetch request and PC
//   icache_hit, icache_data    : same-cycle icache response
//   instr_valid/instr/instr_pc : queue head to decode
//   decode_ready               : decode accepts head
//   stall                      : miss indication (req && !hit)
// Optional macro IFETCH_PERF_CNT_EN adds saturating 32-bit counters
//   perf_miss_cycles, perf_flushes, perf_full_cycles.
module ifetch_queue_stage
  import brisc_pkg::*;
#(
  parameter int                    QUEUE_DEPTH = IFQ_DEPTH,
  parameter int                    PC_WIDTH    = XLEN,
  parameter int                    INSTR_WIDTH = ILEN,
  parameter logic [PC_WIDTH-1:0]   BOOT_PC     = PC_WIDTH'(PC_BOOT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall_fetch,
  input  logic                     redirect,
  input  logic [PC_WIDTH-1:0]      redirect_target,
  output logic                     icache_req,
  output logic [PC_WIDTH-1:0]      icache_addr,
  input  logic                     icache_hit,
  input  logic [INSTR_WIDTH-1:0]   icache_data,
  output logic                     instr_valid,
  output logic [INSTR_WIDTH-1:0]   instr,
  output logic [PC_WIDTH-1:0]      instr_pc,
  input  logic                     decode_ready,
  output logic                     stall
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]              perf_miss_cycles,
  output logic [31:0]              perf_flushes,
  output logic [31:0]              perf_full_cycles
`endif
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [PC_WIDTH-1:0] r_pc;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  entry_t              w_wdata;
  entry_t              w_head;
  logic                w_tgt_unused;

  // Word-aligned fetch: the low target bits are dropped on redirect.
  assign w_tgt_unused = ^redirect_target[1:0];

  // A redirect squashes the head in its own cycle, so decode cannot pop it.
  assign instr_valid = !w_empty && !redirect;
  assign w_pop       = instr_valid && decode_ready;
  // A pop frees a slot this cycle, so a full queue can still accept a fetch.
  assign icache_req  = !reset && !redirect && !stall_fetch && (!w_full || w_pop);
  assign w_push      = icache_req && icache_hit;
  assign stall       = icache_req && !icache_hit;
  assign icache_addr = r_pc;

  // Head fields read as zero whenever nothing valid is presented.
  assign instr    = instr_valid ? w_head.instr : '0;
  assign instr_pc = instr_valid ? w_head.pc    : '0;

  assign w_wdata.pc    = r_pc;
  assign w_wdata.instr = icache_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= BOOT_PC;
    end else if (redirect) begin
      r_pc <= {redirect_target[PC_WIDTH-1:2], 2'b00};
    end else if (w_push) begin
      r_pc <= r_pc + PC_WIDTH'(4);
    end
  end

  ifetch_fifo #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wdata),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_perf_miss;
  logic [31:0] r_perf_flush;
  logic [31:0] r_perf_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_miss  <= '0;
      r_perf_flush <= '0;
      r_perf_full  <= '0;
    end else begin
      if (stall)                                       r_perf_miss  <= sat_inc32(r_perf_miss);
      if (redirect)                                    r_perf_flush <= sat_inc32(r_perf_flush);
      if ((w_count == CNT_W'(QUEUE_DEPTH)) && !w_pop)  r_perf_full  <= sat_inc32(r_perf_full);
    end
  end

  assign perf_miss_cycles = r_perf_miss;
  assign perf_flushes     = r_perf_flush;
  assign perf_full_cycles = r_perf_full;
`else
  logic w_count_unused;
  assign w_count_unused = ^w_count;
`endif

endmodule

// File: tb/tb_ifetch_queue_stage.sv
module tb_ifetch_queue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_fetch;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_hit;
  logic [31:0] icache_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;
  logic        stall;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_miss_cycles;
  logic [31:0] perf_flushes;
  logic [31:0] perf_full_cycles;
`endif

  always #5 clk = ~clk;

  ifetch_queue_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall_fetch     (stall_fetch),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .icache_req      (icache_req),
    .icache_addr     (icache_addr),
    .icache_hit      (icache_hit),
    .icache_data     (icache_data),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .decode_ready    (decode_ready),
    .stall           (stall)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_miss_cycles(perf_miss_cycles),
    .perf_flushes    (perf_flushes),
    .perf_full_cycles(perf_full_cycles)
`endif
  );

  // icache model: the instruction word is a fixed scramble of its address.
  function automatic logic [31:0] dat(input logic [31:0] pc);
    return pc ^ 32'hC0DE_5A00;
  endfunction
  assign icache_data = dat(icache_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = dat(pc);
    sb.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic set_in(input logic rst, input logic h, input logic r,
                        input logic sf = 1'b0, input logic rd = 1'b0,
                        input logic [31:0] tgt = 32'h0);
    @(posedge clk);
    #1;
    reset           = rst;
    icache_hit      = h;
    decode_ready    = r;
    stall_fetch     = sf;
    redirect        = rd;
    redirect_target = tgt;
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0);
    sb.delete();
    chk("rst_req",      {31'd0, icache_req},  32'd0);
    chk("rst_valid",    {31'd0, instr_valid}, 32'd0);
    chk("rst_addr",     icache_addr,          32'h1000);
    chk("rst_instr",    instr,                32'd0);
    chk("rst_instr_pc", instr_pc,             32'd0);
  endtask

  // Monitor: every accepted head is compared against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && instr_valid && decode_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_unexpected: got pc %h, expected no entry", instr_pc);
      end else begin
        e = sb.pop_front();
        chk("pop_pc",    instr_pc, e.pc);
        chk("pop_instr", instr,    e.ins);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall_fetch = 1'b0; redirect = 1'b0; redirect_target = '0;
    icache_hit = 1'b0; decode_ready = 1'b0;

    // Streaming: constant hits with decode always ready.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_in(1'b0, 1'b1, 1'b1);
      chk("s1_addr",  icache_addr, 32'h1000 + 32'(4 * k));
      chk("s1_req",   {31'd0, icache_req},  32'd1);
      chk("s1_valid", {31'd0, instr_valid}, (k != 0) ? 32'd1 : 32'd0);
      exp_push(32'h1000 + 32'(4 * k));
    end
    set_in(1'b0, 1'b0, 1'b1);
    chk("s1_drain_stall", {31'd0, stall}, 32'd1);
    chk("s1_drain_addr",  icache_addr,    32'h1018);
    // stall_fetch holds the PC and blocks the request even on a hit.
    for (int k = 0; k < 2; k++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b1);
      chk("sf_req",   {31'd0, icache_req},  32'd0);
      chk("sf_stall", {31'd0, stall},       32'd0);
      chk("sf_valid", {31'd0, instr_valid}, 32'd0);
      chk("sf_addr",  icache_addr,          32'h1018);
    end
    set_in(1'b0, 1'b1, 1'b1);
    chk("sf_resume_req", {31'd0, icache_req}, 32'd1);
    exp_push(32'h1018);
    set_in(1'b0, 1'b0, 1'b1);
    set_in(1'b0, 1'b0, 1'b0);
    chk("s1_sb_empty", 32'(sb.size()), 32'd0);

    // Back-pressure: fill, hold, push+pop when full, then drain in order.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b1, 1'b0);
      chk("fill_addr", icache_addr, 32'h1000 + 32'(4 * k));
      chk("fill_req",  {31'd0, icache_req}, 32'd1);
      exp_push(32'h1000 + 32'(4 * k));
    end
    for (int k = 0; k < 2; k++) begin
      set_in(1'b0, 1'b1, 1'b0);
      chk("full_req",   {31'd0, icache_req},  32'd0);
      chk("full_stall", {31'd0, stall},       32'd0);
      chk("full_addr",  icache_addr,          32'h1010);
      chk("full_head",  instr_pc,             32'h1000);
    end
    set_in(1'b0, 1'b1, 1'b1);
    chk("pp_req",  {31'd0, icache_req}, 32'd1);
    chk("pp_addr", icache_addr,         32'h1010);
    exp_push(32'h1010);
    set_in(1'b0, 1'b1, 1'b0);
    chk("pp_full_req", {31'd0, icache_req}, 32'd0);
    chk("pp_addr2",    icache_addr,         32'h1014);
    chk("pp_head",     instr_pc,            32'h1004);
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 1'b0, 1'b1);
      chk("drain_valid", {31'd0, instr_valid}, 32'd1);
    end
    set_in(1'b0, 1'b0, 1'b0);
    chk("drain_done",   {31'd0, instr_valid}, 32'd0);
    chk("s2_sb_empty",  32'(sb.size()),       32'd0);
`ifdef IFETCH_PERF_CNT_EN
    chk("perf_full", perf_full_cycles, 32'd3);
`endif

    // Miss: five miss cycles at 0x1008, then fetch resumes there.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_in(1'b0, 1'b1, 1'b1);
      exp_push(32'h1000 + 32'(4 * k));
    end
    for (int k = 0; k < 5; k++) begin
      set_in(1'b0, 1'b0, 1'b1);
      chk("miss_stall", {31'd0, stall},      32'd1);
      chk("miss_req",   {31'd0, icache_req}, 32'd1);
      chk("miss_addr",  icache_addr,         32'h1008);
    end
    set_in(1'b0, 1'b1, 1'b1);
    chk("miss_resume_addr",  icache_addr,    32'h1008);
    chk("miss_resume_stall", {31'd0, stall}, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    chk("perf_miss", perf_miss_cycles, 32'd5);
`endif
    exp_push(32'h1008);
    set_in(1'b0, 1'b1, 1'b1);
    chk("miss_next_addr", icache_addr, 32'h100C);
    exp_push(32'h100C);
    set_in(1'b0, 1'b0, 1'b1);
    set_in(1'b0, 1'b0, 1'b0);
    chk("s3_sb_empty", 32'(sb.size()), 32'd0);

    // Redirect with three queued entries: head squashed, queue flushed.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 1'b1, 1'b0);
      exp_push(32'h1000 + 32'(4 * k));
    end
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2002);
    chk("rd_valid", {31'd0, instr_valid}, 32'd0);
    chk("rd_req",   {31'd0, icache_req},  32'd0);
    chk("rd_stall", {31'd0, stall},       32'd0);
    sb.delete();
    set_in(1'b0, 1'b1, 1'b1);
    chk("rd_addr",   icache_addr,          32'h2000);
    chk("rd_empty",  {31'd0, instr_valid}, 32'd0);
    exp_push(32'h2000);
    set_in(1'b0, 1'b1, 1'b1);
    chk("rd_addr2",  icache_addr,          32'h2004);
    chk("rd_first",  instr_pc,             32'h2000);
    exp_push(32'h2004);
    set_in(1'b0, 1'b0, 1'b1);
    set_in(1'b0, 1'b0, 1'b0);
    chk("s4_sb_empty", 32'(sb.size()), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    chk("perf_flush", perf_flushes, 32'd1);
`endif

    // Reset mid-miss with a partly filled queue.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_in(1'b0, 1'b1, 1'b0);
      exp_push(32'h1000 + 32'(4 * k));
    end
    set_in(1'b0, 1'b0, 1'b0);
    chk("rm_stall", {31'd0, stall}, 32'd1);
    chk("rm_addr",  icache_addr,    32'h1008);
    set_in(1'b1, 1'b0, 1'b0);
    sb.delete();
    set_in(1'b1, 1'b0, 1'b0);
    chk("rm_valid", {31'd0, instr_valid}, 32'd0);
    chk("rm_boot",  icache_addr,          32'h1000);
    chk("rm_req",   {31'd0, icache_req},  32'd0);
`ifdef IFETCH_PERF_CNT_EN
    chk("rm_perf_miss",  perf_miss_cycles, 32'd0);
    chk("rm_perf_flush", perf_flushes,     32'd0);
    chk("rm_perf_full",  perf_full_cycles, 32'd0);
`endif
    set_in(1'b0, 1'b1, 1'b1);
    chk("rm_refetch", icache_addr,         32'h1000);
    chk("rm_req2",    {31'd0, icache_req}, 32'd1);
    exp_push(32'h1000);
    set_in(1'b0, 1'b0, 1'b1);
    set_in(1'b0, 1'b0, 1'b0);
    chk("s6_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue_stage.md
Name: ifetch_queue_stage

Overview:
- Parametrised fetch front-end: PC generation plus an N-entry instruction queue between the icache and decode.
- Fetches sequentially from BOOT_PC whenever the icache hits and the queue has room.
- Decode consumes entries through a valid/ready handshake.
- A redirect (taken branch/jump) flushes the queue and restarts fetch at the target. This decouples icache miss stalls from decode back-pressure.

Parameters:
- QUEUE_DEPTH, 4, instruction queue entries; power of two, >= 2
- BOOT_PC, PC_BOOT (brisc_pkg), PC value loaded on reset
- PC_WIDTH, XLEN, PC and icache address width
- INSTR_WIDTH, ILEN, instruction word width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall_fetch  in  1  hazard-unit hold; freezes PC, no queue push
- redirect  in  1  taken branch/jump; flush and restart
- redirect_target  in  PC_WIDTH  new fetch PC; bits [1:0] ignored
- icache_req  out  1  fetch request valid this cycle
- icache_addr  out  PC_WIDTH  current fetch PC
- icache_hit  in  1  same-cycle hit for icache_addr
- icache_data  in  INSTR_WIDTH  instruction word, valid when icache_hit
- instr_valid  out  1  queue head valid to decode
- instr  out  INSTR_WIDTH  queue head instruction
- instr_pc  out  PC_WIDTH  PC of queue head
- decode_ready  in  1  decode accepts head this cycle
- stall  out  1  icache_req && !icache_hit (miss stall indication)

Behaviour:
- Reset values:
  - pc = BOOT_PC; head = tail = count = 0
  - instr_valid = 0, icache_req = 0 in the reset cycle
  - instr/instr_pc = 0 (queue storage need not be cleared)
- icache_addr = pc, combinational and always driven.
- icache_req = !reset && !redirect && !stall_fetch && (count < QUEUE_DEPTH || pop).
- pop = instr_valid && decode_ready.
- instr_valid = (count != 0) && !redirect. A redirect masks the head in the same cycle; decode never accepts a squashed instruction.
- push = icache_req && icache_hit. On push: entry {pc, icache_data} is written at tail, tail advances, and pc <= pc + 4, wrapping modulo 2^PC_WIDTH.
- Simultaneous push and pop:
  - Allowed when full: count is unchanged, head and tail both advance.
  - Allowed when empty: the entry goes through the queue; there is no same-cycle bypass, so instr_valid rises the next cycle.
- Redirect has priority over everything: count <= 0, head = tail <= 0, pc <= {redirect_target[PC_WIDTH-1:2], 2'b00}. No push or pop that cycle. The first post-redirect entry can appear at instr_valid 2 cycles after redirect at the earliest.
- stall_fetch holds pc and blocks push. Pop continues, so decode drains normally.
- Miss (icache_req && !icache_hit): pc holds and icache_req stays high each cycle until hit. The icache owns the fill and arbiter traffic.
- Fetch latency: hit at cycle t gives instr_valid at t+1.
- Index pointers are log2(QUEUE_DEPTH) bits and wrap naturally. count is log2(QUEUE_DEPTH)+1 bits.
- Reset mid-miss or mid-drain discards everything; the next fetch is at BOOT_PC.

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- With the macro:
  - Adds outputs perf_miss_cycles (32b, increments each cycle stall=1).
  - Adds perf_flushes (32b, increments on each redirect cycle).
  - Adds perf_full_cycles (32b, increments when count == QUEUE_DEPTH and !pop).
  - All three reset to 0, saturate at all-ones, and do not wrap.
- Without the macro: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- brisc_pkg holds:
  - fetch_entry_t typedef {pc, instr}
  - IFQ_DEPTH default constant
  - existing PC_BOOT, XLEN, ILEN
- One sub-module, ifetch_fifo: parametrised synchronous FIFO with push, pop, flush, full, empty and count, storing fetch_entry_t.
- The top holds the PC register, request logic and optional counters.

Test Plan:
- Reset, then icache_hit=1 constantly, decode_ready=1 → icache_addr 0x1000, 0x1004, 0x1008…; instr_valid from cycle 2; instr_pc matches the fetch order.
- decode_ready=0 with hits, QUEUE_DEPTH=4 → exactly 4 pushes; icache_req drops; pc holds at BOOT_PC+0x10. Raising decode_ready then drains entries in order with no loss or duplication.
- icache_hit=0 for 5 cycles at pc 0x1008 → stall=1 for 5 cycles, pc holds, no push; hit resumes fetch at 0x1008. perf_miss_cycles=5 if IFETCH_PERF_CNT_EN is defined.
- Queue holding 3 entries, redirect=1 target 0x2002 with decode_ready=1 → instr_valid=0 that cycle and nothing popped; count=0; next icache_addr 0x2000.
- Full queue with push and pop in the same cycle → count stays 4; the head advances and the new entry lands at the wrapped tail.
- Assert reset mid-miss with a half-full queue → next cycle instr_valid=0, icache_addr=BOOT_PC, all perf counters 0.
